// File: rtl/lcd_timing_gen_p.sv
// lcd_timing_gen_p -- parametrised LCD raster timing generator.
// Produces active-low HD/VD syncs, DEN, pixel X/Y coordinates, a Y-valid flag,
// a frame-start pulse and a wrapping frame counter.
// Starting and stopping happen only on frame boundaries.
// The optional DMA line-prefetch pulse (oLineReq/oReqRow) is built only when
// the macro LCD_TG_PREFETCH_EN is defined. Without it both outputs are tied to 0.
// Every output is registered and reflects the counter position of the
// previous cycle, so the latency is one clock.

module lcd_timing_gen_p #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 1,
    parameter int H_BP     = 215,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 22,
    parameter int V_SYNC   = 1,
    parameter int V_BP     = 22,
    parameter int XW       = 10,
    parameter int YW       = 9,
    parameter int FCW      = 8,
    parameter int PREFETCH = 16
) (
    input  logic           iCLK,
    input  logic           iRST_n,
    input  logic           iEN,
    output logic           oHD,
    output logic           oVD,
    output logic           oDEN,
    output logic [XW-1:0]  oXCoord,
    output logic [YW-1:0]  oYCoord,
    output logic           oYValid,
    output logic           oFrameStart,
    output logic [FCW-1:0] oFrameCnt,
    output logic           oLineReq,
    output logic [YW-1:0]  oReqRow
);

    // ------------------------------------------------------------------
    // Raster geometry
    // ------------------------------------------------------------------
    localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HA0   = H_SYNC + H_BP;          // first visible pixel
    localparam int HA1   = HA0 + H_ACTIVE;         // one past last visible pixel
    localparam int VA0   = V_SYNC + V_BP;          // first visible line
    localparam int VA1   = VA0 + V_ACTIVE;         // one past last visible line

    // Counter widths are sized from the totals, independent of XW/YW.
    localparam int HCW = (H_TOT > 1) ? $clog2(H_TOT) : 1;
    localparam int VCW = (V_TOT > 1) ? $clog2(V_TOT) : 1;

    localparam logic [HCW-1:0] H_LAST = HCW'(H_TOT - 1);
    localparam logic [VCW-1:0] V_LAST = VCW'(V_TOT - 1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------
    generate
        if (PREFETCH < 1 || PREFETCH > H_SYNC + H_BP) begin : g_bad_prefetch
            $error("lcd_timing_gen_p: PREFETCH must lie in 1..H_SYNC+H_BP");
        end
        if (H_ACTIVE > (1 << XW)) begin : g_bad_xw
            $error("lcd_timing_gen_p: H_ACTIVE does not fit in XW bits");
        end
        if (V_ACTIVE > (1 << YW)) begin : g_bad_yw
            $error("lcd_timing_gen_p: V_ACTIVE does not fit in YW bits");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t         state_reg;
    logic [HCW-1:0] h_reg;
    logic [VCW-1:0] v_reg;

    // Decoded view of the current position (registered into the outputs).
    int              h_pos;
    int              v_pos;
    logic            running;
    logic            h_act;
    logic            v_act;
    logic            hd_next;
    logic            vd_next;
    logic            den_next;
    logic            yvalid_next;
    logic            fs_next;
    logic [XW-1:0]   x_next;
    logic [YW-1:0]   y_next;

    // Decode the present counter position into next-cycle output values.
    // Outside RUN every decode collapses to its reset value.
    always_comb begin
        h_pos       = int'(h_reg);
        v_pos       = int'(v_reg);
        running     = (state_reg == ST_RUN);
        h_act       = (h_pos >= HA0) && (h_pos < HA1);
        v_act       = (v_pos >= VA0) && (v_pos < VA1);
        hd_next     = !(running && (h_pos < H_SYNC));
        vd_next     = !(running && (v_pos < V_SYNC));
        den_next    = running && h_act && v_act;
        yvalid_next = running && v_act;
        fs_next     = running && (h_pos == 0) && (v_pos == 0);
        x_next      = '0;
        y_next      = '0;
        if (running && h_act) begin
            x_next = XW'(h_pos - HA0);
        end
        if (running && v_act) begin
            y_next = YW'(v_pos - VA0);
        end
    end

    // Run/stop FSM, raster counters and the registered panel outputs.
    // A stop request is only honoured on the last pixel of the last line,
    // so a frame in progress always completes.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_reg   <= ST_IDLE;
            h_reg       <= '0;
            v_reg       <= '0;
            oHD         <= 1'b1;
            oVD         <= 1'b1;
            oDEN        <= 1'b0;
            oXCoord     <= '0;
            oYCoord     <= '0;
            oYValid     <= 1'b0;
            oFrameStart <= 1'b0;
            oFrameCnt   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    h_reg <= '0;
                    v_reg <= '0;
                    if (iEN) begin
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (h_reg == H_LAST) begin
                        h_reg <= '0;
                        if (v_reg == V_LAST) begin
                            v_reg <= '0;
                            if (!iEN) begin
                                state_reg <= ST_IDLE;
                            end
                        end else begin
                            v_reg <= v_reg + VCW'(1);
                        end
                    end else begin
                        h_reg <= h_reg + HCW'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    h_reg     <= '0;
                    v_reg     <= '0;
                end
            endcase

            oHD         <= hd_next;
            oVD         <= vd_next;
            oDEN        <= den_next;
            oXCoord     <= x_next;
            oYCoord     <= y_next;
            oYValid     <= yvalid_next;
            oFrameStart <= fs_next;
            // The frame counter advances together with the frame-start pulse
            // and wraps silently.
            if (fs_next) begin
                oFrameCnt <= oFrameCnt + FCW'(1);
            end
        end
    end

`ifdef LCD_TG_PREFETCH_EN
    // ------------------------------------------------------------------
    // DMA line prefetch: PREFETCH cycles before the first visible pixel of
    // each visible line, pulse oLineReq and publish the row it concerns.
    // ------------------------------------------------------------------
    localparam int H_REQ = HA0 - PREFETCH;

    logic req_next;

    // The request fires only while running and only on visible lines.
    always_comb begin
        req_next = running && (h_pos == H_REQ) && v_act;
    end

    // Register the pulse and hold the row number until the next pulse.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oLineReq <= 1'b0;
            oReqRow  <= '0;
        end else begin
            oLineReq <= req_next;
            if (req_next) begin
                oReqRow <= YW'(v_pos - VA0);
            end
        end
    end
`else
    // Prefetch disabled: outputs are constant zero.
    assign oLineReq = 1'b0;
    assign oReqRow  = '0;
`endif

endmodule

// File: tb/tb_lcd_timing_gen_p.sv
// tb_lcd_timing_gen_p -- self-checking bench for lcd_timing_gen_p.
// The geometry is small: H 4/1/1/2 and V 3/1/1/1, giving a frame of 8x6 cycles.
// PREFETCH is 2 and FCW is 2.
// Expected values come from a position-in-frame reference model. The model
// tracks a linear index 0..47 and a running flag.
// Directed table vectors and multi-cycle sequences add hand-computed constants.

module tb_lcd_timing_gen_p;

    localparam int H_ACTIVE = 4;
    localparam int H_FP     = 1;
    localparam int H_SYNC   = 1;
    localparam int H_BP     = 2;
    localparam int V_ACTIVE = 3;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 1;
    localparam int V_BP     = 1;
    localparam int XW       = 2;
    localparam int YW       = 2;
    localparam int FCW      = 2;
    localparam int PREFETCH = 2;

    localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int F_TOT = H_TOT * V_TOT;
    localparam int HA0   = H_SYNC + H_BP;
    localparam int VA0   = V_SYNC + V_BP;

`ifdef LCD_TG_PREFETCH_EN
    localparam bit PF_EN = 1'b1;
`else
    localparam bit PF_EN = 1'b0;
`endif

    logic           iCLK = 1'b0;
    logic           iRST_n;
    logic           iEN;
    logic           oHD;
    logic           oVD;
    logic           oDEN;
    logic [XW-1:0]  oXCoord;
    logic [YW-1:0]  oYCoord;
    logic           oYValid;
    logic           oFrameStart;
    logic [FCW-1:0] oFrameCnt;
    logic           oLineReq;
    logic [YW-1:0]  oReqRow;

    lcd_timing_gen_p #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .XW(XW), .YW(YW), .FCW(FCW), .PREFETCH(PREFETCH)
    ) dut (
        .iCLK        (iCLK),
        .iRST_n      (iRST_n),
        .iEN         (iEN),
        .oHD         (oHD),
        .oVD         (oVD),
        .oDEN        (oDEN),
        .oXCoord     (oXCoord),
        .oYCoord     (oYCoord),
        .oYValid     (oYValid),
        .oFrameStart (oFrameStart),
        .oFrameCnt   (oFrameCnt),
        .oLineReq    (oLineReq),
        .oReqRow     (oReqRow)
    );

    always #5 iCLK = ~iCLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: running flag, linear position within the frame,
    // frame count and last requested row; plus the expected outputs.
    bit m_run;
    int m_pos;
    int m_cnt;
    int m_row;
    int e_hd, e_vd, e_den, e_x, e_y, e_yv, e_fs, e_lr;

    typedef struct {
        int p;
        int hd, vd, den, yv, fs, lr;
        int x, y, cnt, row;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_pos = 0;
        m_cnt = 0;
        m_row = 0;
    endtask

    // One clock edge of the reference: the outputs after the edge describe
    // the position held before it; then the position advances.
    task automatic model_edge(input bit en);
        int  h;
        int  v;
        bit  ha;
        bit  va;
        h  = m_pos % H_TOT;
        v  = m_pos / H_TOT;
        ha = (h >= HA0) && (h < HA0 + H_ACTIVE);
        va = (v >= VA0) && (v < VA0 + V_ACTIVE);
        if (m_run) begin
            e_hd  = (h < H_SYNC) ? 0 : 1;
            e_vd  = (v < V_SYNC) ? 0 : 1;
            e_den = (ha && va) ? 1 : 0;
            e_yv  = va ? 1 : 0;
            e_x   = ha ? h - HA0 : 0;
            e_y   = va ? v - VA0 : 0;
            e_fs  = (m_pos == 0) ? 1 : 0;
            if (e_fs == 1) m_cnt = (m_cnt + 1) % (1 << FCW);
            e_lr  = (PF_EN && h == HA0 - PREFETCH && va) ? 1 : 0;
            if (e_lr == 1) m_row = v - VA0;
        end else begin
            e_hd = 1; e_vd = 1; e_den = 0; e_yv = 0;
            e_x = 0; e_y = 0; e_fs = 0; e_lr = 0;
        end
        if (!m_run) begin
            if (en) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end else if (m_pos == F_TOT - 1) begin
            m_pos = 0;
            if (!en) m_run = 1'b0;
        end else begin
            m_pos++;
        end
    endtask

    task automatic check_all();
        chk("hd",     int'(oHD),         e_hd);
        chk("vd",     int'(oVD),         e_vd);
        chk("den",    int'(oDEN),        e_den);
        chk("xcoord", int'(oXCoord),     e_x);
        chk("ycoord", int'(oYCoord),     e_y);
        chk("yvalid", int'(oYValid),     e_yv);
        chk("fstart", int'(oFrameStart), e_fs);
        chk("fcnt",   int'(oFrameCnt),   m_cnt);
        chk("linereq",int'(oLineReq),    e_lr);
        chk("reqrow", int'(oReqRow),     m_row);
    endtask

    // Apply iEN for one clock, advance the model and compare everything.
    task automatic tick(input bit en);
        iEN = en;
        @(posedge iCLK);
        model_edge(en);
        #1;
        check_all();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_hd"},     int'(oHD),         1);
        chk({tag, "_vd"},     int'(oVD),         1);
        chk({tag, "_den"},    int'(oDEN),        0);
        chk({tag, "_x"},      int'(oXCoord),     0);
        chk({tag, "_y"},      int'(oYCoord),     0);
        chk({tag, "_yv"},     int'(oYValid),     0);
        chk({tag, "_fs"},     int'(oFrameStart), 0);
        chk({tag, "_fcnt"},   int'(oFrameCnt),   0);
        chk({tag, "_lreq"},   int'(oLineReq),    0);
        chk({tag, "_reqrow"}, int'(oReqRow),     0);
        $display("reset check %s at t=%0t", tag, $time);
    endtask

    // Assert reset between clock edges and check the outputs clear at once.
    task automatic pulse_reset(input string tag);
        #2;
        iRST_n = 1'b0;
        #1;
        chk_reset(tag);
        model_reset();
        @(negedge iCLK);
        @(negedge iCLK);
        iRST_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int hd_low;
        int vd_low;
        int den_cnt;
        int fs_cnt;
        int hd_idle;
        int last_fs;
        int gap;
        int cyc;

        // position, hd vd den yv fs lr, x y cnt row
        tbl[0]  = '{0,  0,0,0,0,1,0, 0,0,1,0};
        tbl[1]  = '{1,  1,0,0,0,0,0, 0,0,1,0};
        tbl[2]  = '{7,  1,0,0,0,0,0, 0,0,1,0};
        tbl[3]  = '{8,  0,1,0,0,0,0, 0,0,1,0};
        tbl[4]  = '{16, 0,1,0,1,0,0, 0,0,1,0};
        tbl[5]  = '{17, 1,1,0,1,0,1, 0,0,1,0};
        tbl[6]  = '{19, 1,1,1,1,0,0, 0,0,1,0};
        tbl[7]  = '{21, 1,1,1,1,0,0, 2,0,1,0};
        tbl[8]  = '{22, 1,1,1,1,0,0, 3,0,1,0};
        tbl[9]  = '{23, 1,1,0,1,0,0, 0,0,1,0};
        tbl[10] = '{25, 1,1,0,1,0,1, 0,1,1,1};
        tbl[11] = '{29, 1,1,1,1,0,0, 2,1,1,1};
        tbl[12] = '{33, 1,1,0,1,0,1, 0,2,1,2};
        tbl[13] = '{38, 1,1,1,1,0,0, 3,2,1,2};
        tbl[14] = '{40, 0,1,0,0,0,0, 0,0,1,2};
        tbl[15] = '{47, 1,1,0,0,0,0, 0,0,1,2};
        tbl[16] = '{48, 0,0,0,0,1,0, 0,0,2,2};

        iRST_n = 1'b0;
        iEN    = 1'b0;
        model_reset();
        repeat (3) @(posedge iCLK);
        #1;
        chk_reset("por");
        @(negedge iCLK);
        iRST_n = 1'b1;

        // Table-driven first frames: one entry tick shows IDLE, then sample k
        // shows frame position k.
        tick(1'b1);
        k = 0;
        hd_low = 0;
        vd_low = 0;
        for (int i = 0; i < 17; i++) begin
            for (; k <= tbl[i].p; k++) begin
                tick(1'b1);
                if (k < F_TOT && oHD == 1'b0) hd_low++;
                if (k < F_TOT && oVD == 1'b0) vd_low++;
                if (k == tbl[i].p) begin
                    chk("tbl_hd",   int'(oHD),         tbl[i].hd);
                    chk("tbl_vd",   int'(oVD),         tbl[i].vd);
                    chk("tbl_den",  int'(oDEN),        tbl[i].den);
                    chk("tbl_yv",   int'(oYValid),     tbl[i].yv);
                    chk("tbl_fs",   int'(oFrameStart), tbl[i].fs);
                    chk("tbl_lreq", int'(oLineReq),    PF_EN ? tbl[i].lr : 0);
                    chk("tbl_x",    int'(oXCoord),     tbl[i].x);
                    chk("tbl_y",    int'(oYCoord),     tbl[i].y);
                    chk("tbl_fcnt", int'(oFrameCnt),   tbl[i].cnt);
                    chk("tbl_row",  int'(oReqRow),     PF_EN ? tbl[i].row : 0);
                    $display("vec %0d pos %0d hd=%0d vd=%0d den=%0d x=%0d y=%0d fs=%0d cnt=%0d",
                             i, tbl[i].p, oHD, oVD, oDEN, oXCoord, oYCoord, oFrameStart, oFrameCnt);
                end
            end
        end
        chk("hd_low_per_frame", hd_low, V_TOT);
        chk("vd_low_per_frame", vd_low, H_TOT * V_SYNC);

        // Third frame start shows count 3.
        repeat (F_TOT) tick(1'b1);
        chk("fcnt_third_fs", int'(oFrameStart), 1);
        chk("fcnt_third",    int'(oFrameCnt),   3);
        $display("frame 3 start cnt=%0d", oFrameCnt);

        // Drop iEN at h=3,v=2: the frame completes, then IDLE.
        for (int g = 0; g < 2 * F_TOT && m_pos != 2 * H_TOT + 3; g++) tick(1'b1);
        den_cnt = 0;
        for (int g = 0; g < F_TOT - (2 * H_TOT + 3); g++) begin
            tick(1'b0);
            if (oDEN) den_cnt++;
        end
        chk("den_after_drop", den_cnt, 12);
        fs_cnt  = 0;
        hd_idle = 0;
        for (int g = 0; g < 10; g++) begin
            tick(1'b0);
            if (oFrameStart) fs_cnt++;
            if (!oHD || !oVD) hd_idle++;
        end
        chk("idle_frame_starts", fs_cnt, 0);
        chk("idle_sync_lows",    hd_idle, 0);
        $display("stop at frame end: den=%0d idle_fs=%0d", den_cnt, fs_cnt);

        // iEN low then high inside one frame: back-to-back frames.
        tick(1'b1);
        last_fs = -1;
        gap     = 0;
        fs_cnt  = 0;
        for (cyc = 0; cyc < 2 * F_TOT + 4; cyc++) begin
            tick(!(m_pos >= 10 && m_pos < 30));
            if (oFrameStart) begin
                fs_cnt++;
                if (last_fs >= 0) gap = cyc - last_fs;
                last_fs = cyc;
            end
        end
        chk("b2b_fs_count", fs_cnt, 3);
        chk("b2b_gap",      gap,    F_TOT);
        $display("back-to-back frames: starts=%0d gap=%0d", fs_cnt, gap);

        // Asynchronous reset at h=5,v=3, then frame-count wrap 3->0.
        for (int g = 0; g < 2 * F_TOT && m_pos != 3 * H_TOT + 5; g++) tick(1'b1);
        pulse_reset("midframe");
        tick(1'b1);
        fs_cnt = 0;
        for (int g = 0; g < 4 * F_TOT + 4 && fs_cnt < 4; g++) begin
            tick(1'b1);
            if (oFrameStart) fs_cnt++;
        end
        chk("wrap_frames_seen", fs_cnt, 4);
        chk("fcnt_wrap",        int'(oFrameCnt), 0);
        $display("frame count wrap: starts=%0d cnt=%0d", fs_cnt, oFrameCnt);

        // Randomised run/stop traffic with resets at random phases.
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(80, 250);
            for (int j = 0; j < n; j++) begin
                if (r % 2 == 0) tick($urandom_range(0, 15) != 0);
                else            tick($urandom_range(0, 1) != 0);
            end
            pulse_reset("random");
            $display("random round %0d: %0d cycles", r, n);
        end
        repeat (5) tick(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
